// File: rtl/mavg_filter.sv
// mavg_filter: moving-average FIR with a registered product stage and a fully pipelined adder tree
module mavg_filter #(
    parameter int COEFF_BITS  = 8,
    parameter int INPUT_BITS  = 16,
    parameter int OUTPUT_BITS = 32,
    parameter int TAPS        = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic signed [INPUT_BITS-1:0]  original_data,
    output logic signed [OUTPUT_BITS-1:0] filtered_data
);
    localparam int COEFF = (1 << COEFF_BITS) / TAPS;
    localparam logic signed [OUTPUT_BITS-1:0] W_COEFF = OUTPUT_BITS'(COEFF);
    logic signed [INPUT_BITS-1:0]  r_tap  [TAPS];
    // Heap-ordered tree: leaves TAPS-1..2*TAPS-2 hold products, node 0 is the result
    logic signed [OUTPUT_BITS-1:0] r_node [2*TAPS-1];
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < TAPS; k++) r_tap[k] <= '0;
            for (int i = 0; i < 2*TAPS-1; i++) r_node[i] <= '0;
        end else begin
            r_tap[0] <= original_data;
            for (int k = 1; k < TAPS; k++) r_tap[k] <= r_tap[k-1];
            for (int k = 0; k < TAPS; k++)
                r_node[TAPS-1+k] <= OUTPUT_BITS'(r_tap[k]) * W_COEFF;
            for (int i = 0; i < TAPS-1; i++) r_node[i] <= r_node[2*i+1] + r_node[2*i+2];
        end
    end
    assign filtered_data = r_node[0];
endmodule

// File: tb/tb_mavg_filter.sv
// tb_mavg_filter: random and directed stimulus against a sliding-window sum model
module tb_mavg_filter;
    localparam int TAPS  = 16;
    localparam int COEFF = 16;
    localparam int LAT   = 5;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic signed [15:0] original_data = '0;
    logic signed [31:0] filtered_data;
    int total = 0;
    int bad = 0;
    bit run = 1'b0;
    int q[$];

    mavg_filter dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .original_data(original_data),
        .filtered_data(filtered_data)
    );

    always #5 clk_i = ~clk_i;

    // q[0] is the newest capture; reset wipes all history
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) foreach (q[i]) q[i] = 0;
        else begin
            q.push_front(int'(original_data));
            void'(q.pop_back());
        end
    end

    function automatic longint model_out();
        longint s = 0;
        for (int j = LAT; j < LAT + TAPS; j++) s += q[j];
        return s * COEFF;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input longint exp);
        total++;
        if (act !== 32'(exp)) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) if (run) chk("model", filtered_data, model_out());

    task automatic step(input logic signed [15:0] v);
        original_data = v;
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        repeat (TAPS + LAT) q.push_back(0);
        #1 rst_i = 1'b0;
        #1 run = 1'b1;
        chk("reset_async_init", filtered_data, 0);
        repeat (20) begin
            original_data = 16'($urandom);
            @(posedge clk_i);
            #2 chk("reset_hold", filtered_data, 0);
        end
        rst_i = 1'b1;
        step(100);
        repeat (4) step(0);
        chk("impulse_pre", filtered_data, 0);
        repeat (16) begin
            step(0);
            chk("impulse_on", filtered_data, 1600);
        end
        step(0);
        chk("impulse_post", filtered_data, 0);
        repeat (20) step(0);
        repeat (6) step(1000);
        chk("step_ramp1", filtered_data, 16000);
        step(1000);
        chk("step_ramp2", filtered_data, 32000);
        repeat (18) step(1000);
        chk("step_settle", filtered_data, 256000);
        #1 rst_i = 1'b0;
        #1 chk("midreset_async", filtered_data, 0);
        @(posedge clk_i);
        #2 chk("midreset_hold", filtered_data, 0);
        rst_i = 1'b1;
        repeat (5) step(1000);
        chk("midreset_dead", filtered_data, 0);
        step(1000);
        chk("midreset_ramp", filtered_data, 16000);
        repeat (25) step(-16'sd32768);
        chk("neg_fullscale", filtered_data, -8388608);
        repeat (15) begin
            step(1000);
            step(-1000);
        end
        chk("alternating", filtered_data, 0);
        repeat (1000) step(16'($urandom));
        repeat (200) step($urandom_range(0, 1) ? 16'sh7fff : -16'sd32768);
        repeat (30) step(0);
        chk("drain", filtered_data, 0);
        run = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
